// File: rtl/axi4_lite_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave
//   AXI4-Lite slave holding four DATA_W-wide registers. The register index is
//   taken from address bits [3:2]; bits [1:0] are ignored. Full-word writes
//   only (no strobes); every response is OKAY.
//
//   The write and read paths each run their own two-state FSM, so a read and
//   a write can be in flight at the same time. AW and W are captured
//   independently, in either order or together. The register is updated on
//   the edge where the second half is captured.
//
// Ports
//   ACLK                     clock, rising edge
//   ARESETn                  asynchronous reset, active HIGH (despite the name)
//   AWADDR/AWVALID/AWREADY   write address channel
//   WDATA/WVALID/WREADY      write data channel
//   BRESP/BVALID/BREADY      write response channel
//   ARADDR/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RVALID/RREADY read data channel
//   slv_reg0..slv_reg3       live register contents
// -----------------------------------------------------------------------------
module axi4_lite_slave #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // write address channel
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data channel
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  // write response channel
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // read address channel
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data channel
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  // register contents
  output logic [DATA_W-1:0] slv_reg0,
  output logic [DATA_W-1:0] slv_reg1,
  output logic [DATA_W-1:0] slv_reg2,
  output logic [DATA_W-1:0] slv_reg3
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_r [4];

  logic              reg_we_s;
  logic [1:0]        reg_idx_s;
  logic [DATA_W-1:0] reg_data_s;

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  wr_state_t         wr_state_r, wr_state_s;
  logic              aw_done_r, aw_done_s;
  logic              w_done_r, w_done_s;
  logic [1:0]        awidx_r, awidx_s;     // only the index bits are kept
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              awready_r, awready_s;
  logic              wready_r, wready_s;
  logic              bvalid_r, bvalid_s;
  logic              aw_hs_s, w_hs_s;

  // ---------------------------------------------------------------------------
  // Read path state
  // ---------------------------------------------------------------------------
  rd_state_t         rd_state_r, rd_state_s;
  logic              arready_r, arready_s;
  logic              rvalid_r, rvalid_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              ar_hs_s;

  // Address bits outside [3:2] carry no meaning for this block.
  logic              unused_addr_s;

  // Fold the ignored address bits together so they are consumed.
  assign unused_addr_s = ^{AWADDR, ARADDR};

  // Handshake decode from the registered READY flags.
  assign aw_hs_s = AWVALID & awready_r;
  assign w_hs_s  = WVALID  & wready_r;
  assign ar_hs_s = ARVALID & arready_r;

  // Write FSM next-state, capture and register-write decode.
  always_comb begin
    wr_state_s = wr_state_r;
    aw_done_s  = aw_done_r;
    w_done_s   = w_done_r;
    awidx_s    = awidx_r;
    wdata_s    = wdata_r;
    awready_s  = awready_r;
    wready_s   = wready_r;
    bvalid_s   = bvalid_r;
    reg_we_s   = 1'b0;
    reg_idx_s  = 2'b00;
    reg_data_s = '0;

    case (wr_state_r)
      WR_IDLE: begin
        // Each half is latched on its own handshake; the other half may
        // already be held from an earlier cycle.
        if (aw_hs_s) begin
          aw_done_s = 1'b1;
          awidx_s   = AWADDR[3:2];
        end else begin
          aw_done_s = aw_done_r;
          awidx_s   = awidx_r;
        end

        if (w_hs_s) begin
          w_done_s = 1'b1;
          wdata_s  = WDATA;
        end else begin
          w_done_s = w_done_r;
          wdata_s  = wdata_r;
        end

        // Both halves present (possibly just arrived): commit the write.
        if (aw_done_s && w_done_s) begin
          reg_we_s   = 1'b1;
          reg_idx_s  = awidx_s;
          reg_data_s = wdata_s;
          wr_state_s = WR_RESP;
          bvalid_s   = 1'b1;
          awready_s  = 1'b0;
          wready_s   = 1'b0;
        end else begin
          wr_state_s = WR_IDLE;
          bvalid_s   = 1'b0;
          awready_s  = ~aw_done_s;
          wready_s   = ~w_done_s;
        end
      end

      WR_RESP: begin
        awready_s = 1'b0;
        wready_s  = 1'b0;
        // bvalid_r is always set in this state, so BREADY alone completes it.
        if (BREADY) begin
          bvalid_s   = 1'b0;
          aw_done_s  = 1'b0;
          w_done_s   = 1'b0;
          wr_state_s = WR_IDLE;
          awready_s  = 1'b1;
          wready_s   = 1'b1;
        end else begin
          bvalid_s   = 1'b1;
          wr_state_s = WR_RESP;
        end
      end

      default: begin
        wr_state_s = WR_IDLE;
        aw_done_s  = 1'b0;
        w_done_s   = 1'b0;
        awready_s  = 1'b0;
        wready_s   = 1'b0;
        bvalid_s   = 1'b0;
      end
    endcase
  end

  // Write FSM state and write-channel output registers.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      wr_state_r <= WR_IDLE;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      awidx_r    <= 2'b00;
      wdata_r    <= '0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
    end else begin
      wr_state_r <= wr_state_s;
      aw_done_r  <= aw_done_s;
      w_done_r   <= w_done_s;
      awidx_r    <= awidx_s;
      wdata_r    <= wdata_s;
      awready_r  <= awready_s;
      wready_r   <= wready_s;
      bvalid_r   <= bvalid_s;
    end
  end

  // Register file update; a same-edge read still sees the old value.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= '0;
      end
    end else if (reg_we_s) begin
      regs_r[reg_idx_s] <= reg_data_s;
    end
  end

  // Read FSM next-state and read-data capture.
  always_comb begin
    rd_state_s = rd_state_r;
    arready_s  = arready_r;
    rvalid_s   = rvalid_r;
    rdata_s    = rdata_r;

    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) begin
          rdata_s    = regs_r[ARADDR[3:2]];
          rvalid_s   = 1'b1;
          arready_s  = 1'b0;
          rd_state_s = RD_DATA;
        end else begin
          rvalid_s   = 1'b0;
          arready_s  = 1'b1;
          rd_state_s = RD_IDLE;
        end
      end

      RD_DATA: begin
        // RDATA is held untouched until the master accepts it.
        if (RREADY) begin
          rvalid_s   = 1'b0;
          arready_s  = 1'b1;
          rd_state_s = RD_IDLE;
        end else begin
          rvalid_s   = 1'b1;
          arready_s  = 1'b0;
          rd_state_s = RD_DATA;
        end
      end

      default: begin
        rd_state_s = RD_IDLE;
        rvalid_s   = 1'b0;
        arready_s  = 1'b0;
      end
    endcase
  end

  // Read FSM state and read-channel output registers.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      rd_state_r <= RD_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= '0;
    end else begin
      rd_state_r <= rd_state_s;
      arready_r  <= arready_s;
      rvalid_r   <= rvalid_s;
      rdata_r    <= rdata_s;
    end
  end

  assign AWREADY  = awready_r;
  assign WREADY   = wready_r;
  assign BVALID   = bvalid_r;
  assign BRESP    = RESP_OKAY;
  assign ARREADY  = arready_r;
  assign RVALID   = rvalid_r;
  assign RDATA    = rdata_r;
  assign RRESP    = RESP_OKAY;

  assign slv_reg0 = regs_r[0];
  assign slv_reg1 = regs_r[1];
  assign slv_reg2 = regs_r[2];
  assign slv_reg3 = regs_r[3];

endmodule

// File: tb/tb_axi4_lite_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_slave
//   Directed scenarios followed by randomized traffic. A reference model of the
//   four registers observes handshakes on the falling edge (the values that
//   the next rising edge will act on) and pushes expected responses into
//   queues; the same process pops and compares whenever the DUT completes a
//   B or R transfer, and compares the live registers every cycle.
// -----------------------------------------------------------------------------
module tb_axi4_lite_slave;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b1;
  logic [ADDR_W-1:0] AWADDR = '0;
  logic              AWVALID = 1'b0;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA = '0;
  logic              WVALID = 1'b0;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY = 1'b0;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY = 1'b0;
  logic [DATA_W-1:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;

  axi4_lite_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .slv_reg0(slv_reg0), .slv_reg1(slv_reg1),
    .slv_reg2(slv_reg2), .slv_reg3(slv_reg3)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Ready generators: 0 = held low, 1 = held high, 2 = random each cycle
  // ---------------------------------------------------------------------------
  int b_mode = 1;
  int r_mode = 1;

  always @(posedge ACLK) begin
    #1;
    BREADY = (b_mode == 2) ? 1'($urandom_range(0, 1)) : (b_mode == 1);
    RREADY = (r_mode == 2) ? 1'($urandom_range(0, 1)) : (r_mode == 1);
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] model [4];
  logic [DATA_W-1:0] slv [4];
  logic [DATA_W-1:0] r_q [$];
  int                b_q [$];
  bit                b_due, r_due, pend_aw, pend_w;
  logic [1:0]        pend_idx;
  logic [DATA_W-1:0] pend_data;

  always_comb begin
    slv[0] = slv_reg0;
    slv[1] = slv_reg1;
    slv[2] = slv_reg2;
    slv[3] = slv_reg3;
  end

  always @(negedge ACLK) begin
    if (ARESETn) begin
      for (int i = 0; i < 4; i++) model[i] = '0;
      r_q.delete();
      b_q.delete();
      b_due = 0; r_due = 0; pend_aw = 0; pend_w = 0;
    end else begin
      // responses promised by the previous edge
      if (b_due) chk("b_latency", 64'(BVALID), 64'd1);
      if (r_due) chk("r_latency", 64'(RVALID), 64'd1);
      b_due = 0;
      r_due = 0;
      for (int i = 0; i < 4; i++) chk($sformatf("slv_reg%0d", i), 64'(slv[i]), 64'(model[i]));

      if (BVALID && BREADY) begin
        if (b_q.size() == 0) chk("b_unexpected", 64'(BVALID), 64'd0);
        else begin
          void'(b_q.pop_front());
          chk("bresp", 64'(BRESP), 64'd0);
        end
      end
      if (RVALID && RREADY) begin
        if (r_q.size() == 0) chk("r_unexpected", 64'(RVALID), 64'd0);
        else begin
          chk("rdata", 64'(RDATA), 64'(r_q.pop_front()));
          chk("rresp", 64'(RRESP), 64'd0);
        end
      end

      // transfers that the coming edge will complete; reads see the
      // register contents from before any write on the same edge
      if (ARVALID && ARREADY) begin
        r_q.push_back(model[ARADDR[3:2]]);
        r_due = 1;
      end
      if (AWVALID && AWREADY) begin
        pend_aw  = 1;
        pend_idx = AWADDR[3:2];
      end
      if (WVALID && WREADY) begin
        pend_w    = 1;
        pend_data = WDATA;
      end
      if (pend_aw && pend_w) begin
        model[pend_idx] = pend_data;
        b_q.push_back(1);
        b_due   = 1;
        pend_aw = 0;
        pend_w  = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel drivers
  // ---------------------------------------------------------------------------
  task automatic drive_aw(input logic [ADDR_W-1:0] a, input int d);
    int n = 0;
    repeat (d + 1) @(posedge ACLK);
    #1;
    AWADDR = a; AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY && n < 200) begin n++; @(negedge ACLK); end
    if (!AWREADY) chk("aw_timeout", 64'(AWREADY), 64'd1);
    @(posedge ACLK);
    #1 AWVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [DATA_W-1:0] v, input int d);
    int n = 0;
    repeat (d + 1) @(posedge ACLK);
    #1;
    WDATA = v; WVALID = 1'b1;
    @(negedge ACLK);
    while (!WREADY && n < 200) begin n++; @(negedge ACLK); end
    if (!WREADY) chk("w_timeout", 64'(WREADY), 64'd1);
    @(posedge ACLK);
    #1 WVALID = 1'b0;
  endtask

  task automatic drive_ar(input logic [ADDR_W-1:0] a, input int d);
    int n = 0;
    repeat (d + 1) @(posedge ACLK);
    #1;
    ARADDR = a; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 200) begin n++; @(negedge ACLK); end
    if (!ARREADY) chk("ar_timeout", 64'(ARREADY), 64'd1);
    @(posedge ACLK);
    #1 ARVALID = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v,
                          input int da, input int dw);
    fork
      drive_aw(a, da);
      drive_w(v, dw);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // reset values while ARESETn is high
    #3;
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_wready",  64'(WREADY),  64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_bvalid",  64'(BVALID),  64'd0);
    chk("rst_rvalid",  64'(RVALID),  64'd0);
    chk("rst_rdata",   64'(RDATA),   64'd0);
    chk("rst_slv_reg3", 64'(slv_reg3), 64'd0);
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    chk("rel_awready", 64'(AWREADY), 64'd1);
    chk("rel_wready",  64'(WREADY),  64'd1);
    chk("rel_arready", 64'(ARREADY), 64'd1);

    // simultaneous AW/W with BREADY high
    do_write(4'h4, 32'hDEADBEEF, 0, 0);
    @(negedge ACLK);
    chk("sim_slv_reg1", 64'(slv_reg1), 64'hDEADBEEF);
    chk("sim_bvalid",   64'(BVALID),   64'd1);
    chk("sim_bresp",    64'(BRESP),    64'd0);
    @(negedge ACLK);
    chk("sim_bvalid_drop", 64'(BVALID), 64'd0);

    // W first, AW later
    drive_w(32'h12345678, 0);
    @(negedge ACLK);
    chk("wfirst_wready", 64'(WREADY), 64'd0);
    chk("wfirst_reg2_hold", 64'(slv_reg2), 64'd0);
    drive_aw(4'h8, 2);
    @(negedge ACLK);
    chk("wfirst_reg2", 64'(slv_reg2), 64'h12345678);

    // read held off by RREADY low
    do_write(4'hC, 32'hA5A5A5A5, 0, 0);
    r_mode = 0;
    repeat (2) @(posedge ACLK);
    drive_ar(4'hC, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("hold_rvalid",  64'(RVALID),  64'd1);
      chk("hold_rdata",   64'(RDATA),   64'hA5A5A5A5);
      chk("hold_arready", 64'(ARREADY), 64'd0);
    end
    r_mode = 1;
    repeat (3) @(posedge ACLK);

    // unaligned address
    do_write(4'h5, 32'h00000001, 0, 0);
    @(negedge ACLK);
    chk("unal_slv_reg1", 64'(slv_reg1), 64'd1);
    chk("unal_bresp",    64'(BRESP),    64'd0);

    // read and write of the same register on the same edge
    do_write(4'h0, 32'h00000011, 0, 0);
    repeat (2) @(posedge ACLK);
    fork
      do_write(4'h0, 32'h00000022, 0, 0);
      drive_ar(4'h0, 0);
    join
    @(negedge ACLK);
    chk("same_rdata",    64'(RDATA),    64'h11);
    chk("same_slv_reg0", 64'(slv_reg0), 64'h22);
    repeat (3) @(posedge ACLK);

    // randomized traffic
    b_mode = 2;
    r_mode = 2;
    fork
      repeat (40) do_write(4'($urandom_range(0, 15)), $urandom,
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      repeat (40) drive_ar(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    join
    b_mode = 1;
    r_mode = 1;
    repeat (6) @(negedge ACLK);
    chk("drain_b", 64'(b_q.size()), 64'd0);
    chk("drain_r", 64'(r_q.size()), 64'd0);

    // reset with both responses pending
    b_mode = 0;
    r_mode = 0;
    repeat (2) @(posedge ACLK);
    fork
      do_write(4'h8, 32'h00000055, 0, 0);
      drive_ar(4'h4, 0);
    join
    @(negedge ACLK);
    chk("pre_rst_bvalid", 64'(BVALID), 64'd1);
    chk("pre_rst_rvalid", 64'(RVALID), 64'd1);
    #2 ARESETn = 1'b1;
    #1;
    chk("mid_rst_bvalid",  64'(BVALID),  64'd0);
    chk("mid_rst_rvalid",  64'(RVALID),  64'd0);
    chk("mid_rst_awready", 64'(AWREADY), 64'd0);
    chk("mid_rst_regs", 64'(slv_reg0 | slv_reg1 | slv_reg2 | slv_reg3), 64'd0);
    b_mode = 1;
    r_mode = 1;
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    chk("rel2_awready", 64'(AWREADY), 64'd1);
    chk("rel2_wready",  64'(WREADY),  64'd1);
    chk("rel2_arready", 64'(ARREADY), 64'd1);
    chk("rel2_bvalid",  64'(BVALID),  64'd0);

    // a write after reset still works
    do_write(4'hE, 32'hCAFEF00D, 1, 0);
    @(negedge ACLK);
    chk("post_rst_reg3", 64'(slv_reg3), 64'hCAFEF00D);
    repeat (3) @(negedge ACLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave.md
AXI4_LITE_SLAVE -- requirements
Module: axi4_lite_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning AWADDR/ARADDR width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning WDATA/RDATA/register width in bits.
REQ-003 The block SHALL have port ACLK  input  1  clock; all logic is rising-edge.
REQ-004 The block SHALL have port ARESETn  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports AWADDR input ADDR_W, AWVALID input 1, AWREADY output 1, forming the write address channel.
REQ-006 The block SHALL have ports WDATA input DATA_W, WVALID input 1, WREADY output 1, forming the write data channel.
REQ-007 The block SHALL have ports BRESP output 2, BVALID output 1, BREADY input 1, forming the write response channel.
REQ-008 The block SHALL have ports ARADDR input ADDR_W, ARVALID input 1, ARREADY output 1, forming the read address channel.
REQ-009 The block SHALL have ports RDATA output DATA_W, RRESP output 2, RVALID output 1, RREADY input 1, forming the read data channel.
REQ-010 The block SHALL have ports slv_reg0..slv_reg3, each output DATA_W, giving the live contents of registers 0-3.

Function
REQ-011 The block SHALL hold four DATA_W registers; index = address bits [3:2]; bits [1:0] are ignored (no unaligned error).
REQ-012 The write FSM SHALL have states WR_IDLE, WR_RESP; the read FSM SHALL have states RD_IDLE, RD_DATA; both run independently.
REQ-013 In WR_IDLE: AWREADY=1 until an address is captured; WREADY=1 until data is captured; each is latched on its own VALID&READY edge, in either order or the same cycle.
REQ-014 Each captured half SHALL be held with its READY deasserted until the other half arrives; no limit on the gap between halves.
REQ-015 On the edge where the second half is captured, or both together, the addressed register SHALL be written with the full WDATA word (no strobes); the FSM enters WR_RESP.
REQ-016 Latency: the register update and BVALID=1 with BRESP=2'b00 (OKAY) SHALL be visible the cycle after the final AW/W handshake.
REQ-017 In WR_RESP: AWREADY=WREADY=0; BVALID SHALL hold at 1 with stable BRESP until a BVALID&BREADY edge; then both capture flags clear and the FSM returns to WR_IDLE.
REQ-018 In RD_IDLE: ARREADY=1; on ARVALID&ARREADY, RDATA SHALL load the addressed register's value as it stands at that edge; the FSM enters RD_DATA.
REQ-019 In RD_DATA: ARREADY=0, RVALID=1, RRESP=2'b00; RDATA SHALL stay stable until a RVALID&RREADY edge returns the FSM to RD_IDLE.
REQ-020 Read latency SHALL be 1 cycle from the AR handshake to RVALID=1; maximum throughput is one read per 2 cycles and one write per 2 cycles.
REQ-021 Same-register write and read in one edge: RDATA SHALL return the pre-write value; the register takes the new value.
REQ-022 BREADY or RREADY already high when VALID rises SHALL complete the handshake on the first VALID cycle.
REQ-023 Master VALID deasserting before READY (protocol violation) SHALL NOT corrupt state; an uncaptured half is simply not latched.

Reset
REQ-024 While ARESETn=1 (asynchronous), all registers, slv_reg0..3, RDATA and the latched address/data SHALL be 0; BVALID=RVALID=0; BRESP=RRESP=2'b00; AWREADY=WREADY=ARREADY=0.
REQ-025 On ARESETn falling, both FSMs SHALL start in their IDLE states and assert AWREADY=WREADY=ARREADY=1 from the first clock edge.
REQ-026 Reset mid-transaction SHALL abandon it: pending BVALID/RVALID drop at once, partial AW/W captures are discarded, and no register write occurs.

Verification
REQ-027 Simultaneous AW(0x4) and W(0xDEADBEEF), BREADY=1 -> slv_reg1=0xDEADBEEF and BVALID=1/BRESP=00 one cycle later; BVALID low the next cycle.
REQ-028 W(0x12345678) first, AW(0x8) three cycles later -> WREADY low after its handshake; slv_reg2 updates only after the AW handshake.
REQ-029 Write 0xA5A5A5A5 to 0xC, then AR 0xC with RREADY held low 4 cycles -> RVALID stays 1 and RDATA stays 0xA5A5A5A5; ARREADY=0 until RREADY handshake.
REQ-030 Unaligned AW 0x5 with data 0x1 -> slv_reg1=0x1 and BRESP=00.
REQ-031 Reg0=0x11; AR 0x0 and a write of 0x22 to 0x0 complete on the same edge -> RDATA=0x11, slv_reg0=0x22.
REQ-032 Assert ARESETn while BVALID=1 and RVALID=1 -> both drop immediately; all slv_reg=0; READY signals return to 1 on the first edge after release.
